asym_ram_sdp_ratio: RTL and testbench

Parametrised single-clock simple-dual-port asymmetric RAM for sample/waveform buffers. It supports write-wider, read-wider and equal-width configurations from one parameter set. It adds per-lane write enables, a configurable read latency with a valid strobe, and a hardware clear sequencer. It sits between the host-side register/DMA write path and the DSP-side playback read path.

---
 rtl/asym_ram_sdp_ratio.sv | 142 ++++++++++++++
 tb/tb_asym_ram_sdp_ratio.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asym_ram_sdp_ratio.sv
// Single-clock simple-dual-port RAM with asymmetric port widths, per-lane write enables,
// configurable read latency with valid strobe, and a hardware clear sequencer.
module asym_ram_sdp_ratio #(
  parameter int unsigned WWIDTH    = 16,
  parameter int unsigned RWIDTH    = 4,
  parameter int unsigned WDEPTH    = 256,
  parameter int unsigned RLAT      = 3,
  parameter logic [((WWIDTH < RWIDTH) ? WWIDTH : RWIDTH)-1:0] CLR_VALUE = '0,
  parameter string       RAM_STYLE = "block",
  parameter string       INIT_FILE = "",
  localparam int unsigned MINW     = (WWIDTH < RWIDTH) ? WWIDTH : RWIDTH,
  localparam int unsigned NLANE    = WWIDTH / MINW,
  localparam int unsigned RDEPTH   = WDEPTH * WWIDTH / RWIDTH,
  localparam int unsigned WAW      = $clog2(WDEPTH),
  localparam int unsigned RAW      = $clog2(RDEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [NLANE-1:0]  wlane_i,
  input  logic [WAW-1:0]    waddr_i,
  input  logic [WWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [RAW-1:0]    raddr_i,
  output logic [RWIDTH-1:0] rdata_o,
  output logic              rvalid_o,
  input  logic              clr_i,
  output logic              busy_o
);

  // Cells read per read word (1 unless the read port is wider).
  localparam int unsigned RPL   = RWIDTH / MINW;
  localparam int unsigned NCELL = WDEPTH * NLANE;
  localparam int unsigned CAW   = $clog2(NCELL);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [WAW-1:0]   clr_cnt_q, clr_cnt_d;

  logic              wr_en_q, wr_en_d;
  logic [NLANE-1:0]  wlane_q;
  logic [WAW-1:0]    waddr_q;
  logic [WWIDTH-1:0] wdata_q;

  (* ram_style = RAM_STYLE, init_file = INIT_FILE *)
  logic [MINW-1:0]   mem_q [NCELL];

  logic [RWIDTH-1:0] rd_word;
  logic [RWIDTH-1:0] data_q [RLAT];
  logic [RLAT-1:0]   vld_q;

  // Clear FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear FSM: next state.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + WAW'(1);
        if (clr_cnt_q == WAW'(WDEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Clear FSM: outputs.
  always_comb begin
    busy_o = (state_q == StClear);
  end

  // Host writes are dropped, not queued, while the clear sequence owns the array.
  assign wr_en_d = we_i && (state_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_q <= 1'b0;
      wlane_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      wlane_q <= wlane_i;
      waddr_q <= waddr_i;
      wdata_q <= wdata_i;
    end
  end

  // Clear write sits after the host write so it wins a same-edge collision on one cell.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NLANE; k++) begin
      if (wr_en_q && wlane_q[k]) begin
        mem_q[CAW'(NLANE * 32'(waddr_q) + 32'(k))] <= wdata_q[k*MINW +: MINW];
      end
      if (state_q == StClear) begin
        mem_q[CAW'(NLANE * 32'(clr_cnt_q) + 32'(k))] <= CLR_VALUE;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int j = 0; j < RPL; j++) begin
      rd_word[j*MINW +: MINW] = mem_q[CAW'(RPL * 32'(raddr_i) + 32'(j))];
    end
  end

  // Data stages only load behind a valid, so the output holds while rvalid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int s = 0; s < RLAT; s++) data_q[s] <= '0;
    end else begin
      vld_q[0] <= re_i;
      if (re_i) data_q[0] <= rd_word;
      for (int s = 1; s < RLAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  assign rdata_o  = data_q[RLAT-1];
  assign rvalid_o = vld_q[RLAT-1];

endmodule

// File: tb/tb_asym_ram_sdp_ratio.sv
// Scoreboard bench for asym_ram_sdp_ratio: write-wider default instance plus a read-wider
// instance; expected read data queued at issue and popped when rvalid appears.
module tb_asym_ram_sdp_ratio;

  localparam int unsigned RLAT = 3;

  logic        clk;
  logic        rst_n;
  logic        we, re, clr, rvalid, busy;
  logic [3:0]  wlane;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic [9:0]  raddr;
  logic [3:0]  rdata;

  logic        we2, re2, clr2, rvalid2, busy2;
  logic [0:0]  wlane2;
  logic [9:0]  waddr2;
  logic [3:0]  wdata2;
  logic [7:0]  raddr2;
  logic [15:0] rdata2;

  logic [3:0]  mdl [1024];
  logic [3:0]  exp_q [$];
  logic [15:0] exp2_q [$];
  int          n_chk;
  int          n_fail;

  asym_ram_sdp_ratio #(
    .WWIDTH(16), .RWIDTH(4), .WDEPTH(256), .RLAT(RLAT)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .wlane_i(wlane), .waddr_i(waddr),
    .wdata_i(wdata), .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
    .clr_i(clr), .busy_o(busy)
  );

  asym_ram_sdp_ratio #(
    .WWIDTH(4), .RWIDTH(16), .WDEPTH(1024), .RLAT(1)
  ) u_dut_rw (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we2), .wlane_i(wlane2), .waddr_i(waddr2),
    .wdata_i(wdata2), .re_i(re2), .raddr_i(raddr2), .rdata_o(rdata2), .rvalid_o(rvalid2),
    .clr_i(clr2), .busy_o(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] pat(int w, int seed);
    logic [15:0] p;
    for (int k = 0; k < 4; k++) p[k*4 +: 4] = 4'(((w + k + seed) % 15) + 1);
    return p;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [3:0] l);
    we = 1'b1; waddr = a; wdata = d; wlane = l;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    for (int k = 0; k < 4; k++) if (l[k]) mdl[int'(a) * 4 + k] = d[k*4 +: 4];
  endtask

  task automatic test_reset();
    logic ev;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      re = ~re; raddr = 10'(i);
      @(posedge clk);
      @(negedge clk);
      n_chk += 3;
      if (rdata !== 4'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    re = 1'b0;
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < RLAT + 2; i++) begin
      re = (i == 0); raddr = 10'h0;
      @(posedge clk);
      @(negedge clk);
      ev = (i == RLAT - 1);
      n_chk++;
      if (rvalid !== ev) begin
        n_fail++; $display("FAIL reset_first_rvalid cycle %0d: got %b want %b", i, rvalid, ev);
      end
    end
  endtask

  task automatic test_write_wider();
    logic [9:0] a [4];
    logic [3:0] e [4];
    logic [3:0] got;
    logic       ev;
    a = '{10'h14, 10'h15, 10'h16, 10'h17};
    e = '{4'hD, 4'hC, 4'hB, 4'hA};
    do_write(8'h05, 16'hABCD, 4'hF);
    idle(1);
    for (int i = 0; i < 4 + RLAT; i++) begin
      re = (i < 4);
      if (i < 4) begin raddr = a[i]; exp_q.push_back(e[i]); end
      @(posedge clk);
      @(negedge clk);
      ev = (i >= RLAT - 1) && (i < RLAT + 3);
      n_chk++;
      if (rvalid !== ev) begin
        n_fail++; $display("FAIL ww_rvalid cycle %0d: got %b want %b", i, rvalid, ev);
      end
      if (rvalid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_chk++;
        if (rdata !== got) begin n_fail++; $display("FAIL ww_rdata: got %h want %h", rdata, got); end
      end
    end
    re = 1'b0;
    idle(2);
    n_chk++;
    if (rdata !== 4'hA) begin n_fail++; $display("FAIL ww_hold: got %h want a", rdata); end
  endtask

  task automatic test_lane_mask();
    logic [3:0] e [4];
    logic [3:0] got;
    e = '{4'h4, 4'hC, 4'h2, 4'hA};
    do_write(8'h05, 16'h1234, 4'b0101);
    idle(1);
    for (int i = 0; i < 4 + RLAT; i++) begin
      re = (i < 4);
      if (i < 4) begin raddr = 10'h14 + 10'(i); exp_q.push_back(e[i]); end
      @(posedge clk);
      @(negedge clk);
      if (rvalid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_chk++;
        if (rdata !== got) begin n_fail++; $display("FAIL lane_rdata: got %h want %h", rdata, got); end
      end
    end
    re = 1'b0;
  endtask

  task automatic test_collision();
    logic [3:0] got;
    logic       ev;
    do_write(8'h05, 16'hABCD, 4'hF);
    idle(1);
    for (int i = 0; i < RLAT + 3; i++) begin
      we = (i == 0); waddr = 8'h05; wdata = 16'h1111; wlane = 4'hF;
      re = (i == 1 || i == 2); raddr = 10'h14;
      if (i == 1) exp_q.push_back(4'hD);
      if (i == 2) exp_q.push_back(4'h1);
      @(posedge clk);
      @(negedge clk);
      ev = (i == RLAT) || (i == RLAT + 1);
      n_chk++;
      if (rvalid !== ev) begin
        n_fail++; $display("FAIL coll_rvalid cycle %0d: got %b want %b", i, rvalid, ev);
      end
      if (rvalid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_chk++;
        if (rdata !== got) begin n_fail++; $display("FAIL coll_rdata: got %h want %h", rdata, got); end
      end
    end
    we = 1'b0; re = 1'b0;
    for (int k = 0; k < 4; k++) mdl[20 + k] = 4'h1;
  endtask

  task automatic test_clear();
    int         cnt;
    int         bad;
    logic [3:0] got;
    logic       ev;
    for (int w = 0; w < 256; w++) do_write(8'(w), pat(w, 3), 4'hF);
    idle(1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      we = (cnt % 3 == 0); waddr = 8'(cnt); wdata = 16'hFFFF; wlane = 4'hF;
      clr = (cnt == 50);
      @(posedge clk);
      @(negedge clk);
    end
    we = 1'b0; clr = 1'b0;
    n_chk++;
    if (cnt != 256) begin n_fail++; $display("FAIL clr_busy_cycles: got %0d want 256", cnt); end
    for (int c = 0; c < 1024; c++) mdl[c] = 4'h0;
    bad = 0;
    for (int i = 0; i < 1024 + RLAT; i++) begin
      re = (i < 1024);
      if (i < 1024) begin raddr = 10'(i); exp_q.push_back(mdl[i]); end
      @(posedge clk);
      @(negedge clk);
      ev = (i >= RLAT - 1) && (i < 1024 + RLAT - 1);
      n_chk++;
      if (rvalid !== ev) begin
        n_fail++; $display("FAIL clr_rvalid cycle %0d: got %b want %b", i, rvalid, ev);
      end
      if (rvalid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_chk++;
        if (rdata !== got && bad < 8) begin
          bad++; $display("FAIL clr_rdata cycle %0d: got %h want %h", i, rdata, got);
        end
        if (rdata !== got) n_fail++;
      end
    end
    re = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int         bad;
    logic [3:0] got;
    for (int w = 0; w < 256; w++) do_write(8'(w), pat(w, 7), 4'hF);
    idle(1);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    re = 1'b1; raddr = 10'h3;
    repeat (100) @(posedge clk);
    #2;
    n_chk += 2;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy_before: got %b want 1", busy); end
    if (rvalid !== 1'b1) begin
      n_fail++; $display("FAIL midclr_rvalid_before: got %b want 1", rvalid);
    end
    rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midclr_busy_async: got %b want 0", busy); end
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL midclr_rvalid_drop: got %b want 0", rvalid); end
    re = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) mdl[c] = 4'h0;
    idle(1);
    bad = 0;
    for (int i = 0; i < 1024 + RLAT; i++) begin
      re = (i < 1024);
      if (i < 1024) begin raddr = 10'(i); exp_q.push_back(mdl[i]); end
      @(posedge clk);
      @(negedge clk);
      if (rvalid === 1'b1 && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        n_chk++;
        if (rdata !== got && bad < 8) begin
          bad++; $display("FAIL midclr_rdata cycle %0d: got %h want %h", i, rdata, got);
        end
        if (rdata !== got) n_fail++;
      end
    end
    re = 1'b0;
  endtask

  task automatic test_read_wider();
    logic [15:0] got;
    logic        ev;
    for (int i = 0; i < 8; i++) begin
      we2 = 1'b1; wlane2 = 1'b1; waddr2 = 10'(i); wdata2 = 4'(i + 1);
      @(posedge clk);
      @(negedge clk);
    end
    we2 = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      re2 = (i < 2); raddr2 = 8'(i);
      if (i == 0) exp2_q.push_back(16'h4321);
      if (i == 1) exp2_q.push_back(16'h8765);
      @(posedge clk);
      @(negedge clk);
      ev = (i < 2);
      n_chk++;
      if (rvalid2 !== ev) begin
        n_fail++; $display("FAIL rw_rvalid cycle %0d: got %b want %b", i, rvalid2, ev);
      end
      if (rvalid2 === 1'b1 && exp2_q.size() > 0) begin
        got = exp2_q.pop_front();
        n_chk++;
        if (rdata2 !== got) begin n_fail++; $display("FAIL rw_rdata: got %h want %h", rdata2, got); end
      end
    end
    re2 = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; clr = 1'b0; wlane = '0; waddr = '0; wdata = '0; raddr = '0;
    we2 = 1'b0; re2 = 1'b0; clr2 = 1'b0; wlane2 = '0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
    for (int c = 0; c < 1024; c++) mdl[c] = 4'h0;
    @(negedge clk);
    test_reset();
    test_write_wider();
    test_lane_mask();
    test_collision();
    test_clear();
    test_reset_mid_clear();
    test_read_wider();
    n_chk++;
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp_q.size(), exp2_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
